mem_access_unit: RTL and testbench

- Initiator side of the data-memory interface: accepts load/store requests from the pipeline and drives the word-addressed data RAM port.
- RAM port: we, 10-bit word address, 32-bit din/dout, 1-cycle registered read.
- Performs byte-lane selection, sign/zero extension on loads and read-modify-write for sub-word stores.
- Returns one response per request through a valid/ready handshake.

---
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake and data-RAM port of the load/store unit.
// Latency: none, this is wiring only.
// Backpressure: carried by the req_valid/req_ready and resp_valid/resp_ready pairs.
interface mem_access_unit_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    // The load/store unit: consumes requests, produces responses, drives the RAM.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_addr, mem_din
    );

    // The pipeline plus RAM side facing the unit.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a word-addressed RAM (lane select, load extension, sub-word RMW).
// Latency accept->resp_valid: load 3, word store 2, sub-word store 4, error 1; all outputs registered.
// Backpressure: one request in flight, req_ready only in IDLE; response held until resp_ready.
// MAU_MISALIGN_TRAP_EN: when defined, misaligned half/word accesses error out; otherwise alignment bits are dropped.
module mem_access_unit #(
    parameter int ADDR_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t            r_state, w_state_nxt;

    // Request fields latched at accept time.
    logic              r_we, w_we_nxt;
    logic [1:0]        r_size, w_size_nxt;
    logic              r_unsigned, w_unsigned_nxt;
    logic [1:0]        r_off, w_off_nxt;
    logic [15:0]       r_wdata, w_wdata_nxt;

    // Registered outputs.
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_resp_valid, w_resp_valid_nxt;
    logic [31:0]       r_resp_rdata, w_resp_rdata_nxt;
    logic              r_resp_err, w_resp_err_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-3:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0]       r_mem_din, w_mem_din_nxt;

    // Request decode.
    logic              w_err;
    logic [1:0]        w_off_in;

`ifdef MAU_MISALIGN_TRAP_EN
    logic              w_misaligned;
    assign w_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign w_err        = (bus.req_size == 2'b11) || w_misaligned;
    assign w_off_in     = bus.req_addr[1:0];
`else
    // Alignment bits below the access size are ignored rather than trapped.
    assign w_err        = (bus.req_size == 2'b11);
    assign w_off_in     = (bus.req_size == 2'b10) ? 2'b00 :
                          (bus.req_size == 2'b01) ? {bus.req_addr[1], 1'b0} :
                                                    bus.req_addr[1:0];
`endif

    // Lane datapath, only meaningful while mem_dout is valid (CAP).
    logic [4:0]        w_shift;
    logic [31:0]       w_lane;
    logic [31:0]       w_load;
    logic [31:0]       w_mask;
    logic [31:0]       w_ins;
    logic [31:0]       w_merge;

    assign w_shift = {r_off, 3'b000};
    assign w_lane  = bus.mem_dout >> w_shift;
    assign w_merge = (bus.mem_dout & ~w_mask) | (w_ins & w_mask);

    // Extend the selected byte/half of the read word into a load result.
    always_comb begin
        w_load = bus.mem_dout;
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'd0, w_lane[7:0]}
                                         : {{24{w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load = r_unsigned ? {16'd0, w_lane[15:0]}
                                         : {{16{w_lane[15]}}, w_lane[15:0]};
            default: w_load = bus.mem_dout;
        endcase
    end

    // Lane mask and positioned store data for the read-modify-write merge.
    always_comb begin
        w_mask = 32'h0000_FFFF << w_shift;
        w_ins  = {16'd0, r_wdata} << w_shift;
        if (r_size == 2'b00) begin
            w_mask = 32'h0000_00FF << w_shift;
            w_ins  = {24'd0, r_wdata[7:0]} << w_shift;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt      = r_state;
        w_we_nxt         = r_we;
        w_size_nxt       = r_size;
        w_unsigned_nxt   = r_unsigned;
        w_off_nxt        = r_off;
        w_wdata_nxt      = r_wdata;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_din_nxt    = r_mem_din;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_we_nxt         = bus.req_we;
                    w_size_nxt       = bus.req_size;
                    w_unsigned_nxt   = bus.req_unsigned;
                    w_off_nxt        = w_off_in;
                    w_wdata_nxt      = bus.req_wdata[15:0];
                    w_resp_rdata_nxt = 32'd0;
                    w_resp_err_nxt   = w_err;
                    if (w_err) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_mem_addr_nxt = bus.req_addr[ADDR_W-1:2];
                        if (bus.req_we && (bus.req_size == 2'b10)) begin
                            w_mem_din_nxt = bus.req_wdata;
                            w_state_nxt   = WR;
                        end else begin
                            w_state_nxt = RD;
                        end
                    end
                end
            end
            RD:   w_state_nxt = CAP;
            CAP: begin
                if (r_we) begin
                    w_mem_din_nxt = w_merge;
                    w_state_nxt   = WR;
                end else begin
                    w_resp_rdata_nxt = w_load;
                    w_state_nxt      = RESP;
                end
            end
            WR:   w_state_nxt = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Handshake and write-enable outputs follow the state being entered.
        w_req_ready_nxt  = (w_state_nxt == IDLE);
        w_resp_valid_nxt = (w_state_nxt == RESP);
        w_mem_we_nxt     = (w_state_nxt == WR);
    end

    // State, latched request and output registers; reset aborts any access in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_off        <= 2'b00;
            r_wdata      <= 16'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_we         <= w_we_nxt;
            r_size       <= w_size_nxt;
            r_unsigned   <= w_unsigned_nxt;
            r_off        <= w_off_nxt;
            r_wdata      <= w_wdata_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_din    <= w_mem_din_nxt;
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store sequence against a behavioural 1024-word RAM.
// Latency of each response is measured in cycles from the accept edge.
// Includes response backpressure and a reset in the middle of a sub-word store.
module tb_mem_access_unit;
    localparam int ADDR_W = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [31:0] ram [0:1023];
    int          n_vec     = 0;
    int          n_err     = 0;
    int          we_pulses = 0;
    logic        we_prev   = 1'b0;
    logic        we_dbl    = 1'b0;

    // RAM: write on the falling edge, registered read on the rising edge.
    always @(negedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    always @(posedge clk) bus.mem_dout <= ram[bus.mem_addr];

    // Count write pulses and flag any back-to-back write cycles.
    always @(posedge clk) begin
        if (bus.mem_we) we_pulses <= we_pulses + 1;
        if (bus.mem_we && we_prev) we_dbl <= 1'b1;
        we_prev <= bus.mem_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ctl"},   {28'd0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_we}, 32'h8);
        chk({tag, ".rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, ".addr"},  {22'd0, bus.mem_addr}, 32'd0);
        chk({tag, ".din"},   bus.mem_din, 32'd0);
    endtask

    // Called at a falling edge with the unit idle; returns at the falling edge after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid    = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_we);
        int lat;
        int we0;
        we0 = we_pulses;
        issue(we, size, uns, addr, wdata);
        wait_resp(lat);
        chk({tag, ".lat"},   lat, exp_lat);
        chk({tag, ".rdata"}, bus.resp_rdata, exp_rdata);
        chk({tag, ".err"},   {31'd0, bus.resp_err}, {31'd0, exp_err});
        finish_resp();
        chk({tag, ".we"},    we_pulses - we0, exp_we);
    endtask

    initial begin
        int lat;
        int we0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'd0;
        bus.resp_ready   = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Word store then load.
        do_op("sw010", 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        chk("sw010.ram", ram[4], 32'hDEADBEEF);
        do_op("lw010", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
        chk("lw010.addr", {22'd0, bus.mem_addr}, 32'h004);

        // Sub-word read-modify-write.
        do_op("sw020", 1'b1, 2'b10, 1'b0, 12'h020, 32'h11223344, 32'h0, 1'b0, 2, 1);
        do_op("sb021", 1'b1, 2'b00, 1'b0, 12'h021, 32'hFFFFFFAA, 32'h0, 1'b0, 4, 1);
        chk("sb021.ram", ram[8], 32'h1122AA44);
        do_op("sh022", 1'b1, 2'b01, 1'b0, 12'h022, 32'h1234BEEF, 32'h0, 1'b0, 4, 1);
        chk("sh022.ram", ram[8], 32'hBEEFAA44);
        do_op("lw020", 1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'hBEEFAA44, 1'b0, 3, 0);

        // Sign and zero extension.
        do_op("sw030", 1'b1, 2'b10, 1'b0, 12'h030, 32'h80FF7F01, 32'h0, 1'b0, 2, 1);
        do_op("lb032",  1'b0, 2'b00, 1'b0, 12'h032, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 0);
        do_op("lbu032", 1'b0, 2'b00, 1'b1, 12'h032, 32'h0, 32'h000000FF, 1'b0, 3, 0);
        do_op("lh032",  1'b0, 2'b01, 1'b0, 12'h032, 32'h0, 32'hFFFF80FF, 1'b0, 3, 0);
        do_op("lhu032", 1'b0, 2'b01, 1'b1, 12'h032, 32'h0, 32'h000080FF, 1'b0, 3, 0);
        do_op("lb031",  1'b0, 2'b00, 1'b0, 12'h031, 32'h0, 32'h0000007F, 1'b0, 3, 0);
        do_op("lb033",  1'b0, 2'b00, 1'b0, 12'h033, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0);
        do_op("lh030",  1'b0, 2'b01, 1'b0, 12'h030, 32'h0, 32'h00007F01, 1'b0, 3, 0);

        // Illegal size always errors without touching the RAM.
        do_op("ill030", 1'b0, 2'b11, 1'b0, 12'h030, 32'h0, 32'h0, 1'b1, 1, 0);
        do_op("illst",  1'b1, 2'b11, 1'b0, 12'h030, 32'h12345678, 32'h0, 1'b1, 1, 0);
        chk("illst.ram", ram[12], 32'h80FF7F01);

        // Misaligned accesses.
`ifdef MAU_MISALIGN_TRAP_EN
        do_op("lw012",  1'b0, 2'b10, 1'b0, 12'h012, 32'h0, 32'h0, 1'b1, 1, 0);
        do_op("lhu033", 1'b0, 2'b01, 1'b1, 12'h033, 32'h0, 32'h0, 1'b1, 1, 0);
`else
        do_op("lw012",  1'b0, 2'b10, 1'b0, 12'h012, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
        do_op("lhu033", 1'b0, 2'b01, 1'b1, 12'h033, 32'h0, 32'h000080FF, 1'b0, 3, 0);
`endif

        // Backpressure: response held, next request waits for the handshake.
        issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
        wait_resp(lat);
        chk("bp.lat", lat, 3);
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 12'h010;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp.rdata", bus.resp_rdata, 32'hBEEFAA44);
            chk("bp.ready", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("bp.done.valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("bp.done.ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_resp(lat);
        chk("bp2.lat", lat, 3);
        chk("bp2.rdata", bus.resp_rdata, 32'hDEADBEEF);
        finish_resp();

        // Asynchronous reset while a byte store sits in CAP.
        we0 = we_pulses;
        issue(1'b1, 2'b00, 1'b0, 12'h030, 32'h00000055);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst.ram", ram[12], 32'h80FF7F01);
        chk("midrst.we", we_pulses - we0, 0);
        do_op("post", 1'b0, 2'b10, 1'b0, 12'h030, 32'h0, 32'h80FF7F01, 1'b0, 3, 0);

        chk("we.single", {31'd0, we_dbl}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
